timer_multi_core: RTL and testbench

Multi-channel, parametrised timer core for the application FPGA timer peripheral. It provides NUM_CH independent counters, each with its own prescaler counter. Each channel runs in one-shot, periodic (auto-reload) or free-running mode. Channels report a registered terminal-event pulse and a sticky event flag that an API wrapper can expose as status or interrupt. The core sits behind the bus-facing timer register block, which drives its start/stop/clear strobes and configuration words.

---
 rtl/timer_multi_core_if.sv | 29 ++
 rtl/timer_multi_core.sv | 135 +++++++++++++
 tb/tb_timer_multi_core.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_multi_core_if.sv
// Bus bundle between the timer register block (master) and timer_multi_core (slave).
// Per-channel fields are packed [channel][bit], matching channel i at bits [i*W +: W].
interface timer_multi_core_if #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 32
);
    logic [PRESC_WIDTH-1:0]         prescaler_init;
    logic [NUM_CH-1:0][WIDTH-1:0]   ch_limit;
    logic [NUM_CH-1:0][1:0]         ch_mode;
    logic [NUM_CH-1:0]              start;
    logic [NUM_CH-1:0]              stop;
    logic [NUM_CH-1:0]              event_clr;
    logic [NUM_CH-1:0][WIDTH-1:0]   curr_timer;
    logic [NUM_CH-1:0]              running;
    logic [NUM_CH-1:0]              event_pulse;
    // sticky terminal-event flag ("event" is a reserved word)
    logic [NUM_CH-1:0]              event_flag;

    modport master (
        output prescaler_init, ch_limit, ch_mode, start, stop, event_clr,
        input  curr_timer, running, event_pulse, event_flag
    );

    modport slave (
        input  prescaler_init, ch_limit, ch_mode, start, stop, event_clr,
        output curr_timer, running, event_pulse, event_flag
    );
endinterface

// File: rtl/timer_multi_core.sv
// Multi-channel timer core: NUM_CH independent IDLE/RUN channels sharing one prescale divisor.
// Each channel runs one-shot, periodic or free-running and reports a pulse plus sticky event.
module timer_multi_core_ch #(
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [PRESC_WIDTH-1:0] presc_init_i,
    input  logic [WIDTH-1:0]       limit_i,
    input  logic [1:0]             mode_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   event_clr_i,
    output logic [WIDTH-1:0]       timer_o,
    output logic                   running_o,
    output logic                   event_pulse_o,
    output logic                   event_o
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d, presc_last;
    logic [WIDTH-1:0]       timer_q, timer_d, limit_last;
    logic                   pulse_q, flag_q, hit;
    logic                   tick, mode_free, mode_per;

    // P=0 behaves as P=1; L=0 wraps to all-ones so the count spans 2^WIDTH
    assign presc_last = (presc_init_i == '0) ? '0 : presc_init_i - PRESC_WIDTH'(1);
    assign limit_last = limit_i - WIDTH'(1);
    assign tick       = (presc_q == presc_last);
    assign mode_free  = (mode_i == 2'd2);
    assign mode_per   = (mode_i == 2'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            timer_q <= '0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            timer_q <= timer_d;
            pulse_q <= hit;
            flag_q  <= hit | (flag_q & ~event_clr_i);
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        timer_d = timer_q;
        hit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    presc_d = '0;
                    timer_d = '0;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    presc_d = '0;
                    timer_d = '0;
                end else if (tick) begin
                    presc_d = '0;
                    if (mode_free) begin
                        timer_d = timer_q + WIDTH'(1);
                        hit     = &timer_q;
                    end else if (timer_q == limit_last) begin
                        hit = 1'b1;
                        // mode 3 falls through to one-shot behaviour
                        if (mode_per) timer_d = '0;
                        else          state_d = IDLE;
                    end else begin
                        timer_d = timer_q + WIDTH'(1);
                    end
                end else begin
                    presc_d = presc_q + PRESC_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running_o     = (state_q == RUN);
        timer_o       = timer_q;
        event_pulse_o = pulse_q;
        event_o       = flag_q;
    end
endmodule

module timer_multi_core #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    timer_multi_core_if.slave bus
);
    logic [NUM_CH-1:0][WIDTH-1:0] timer_w;
    logic [NUM_CH-1:0]            running_w, pulse_w, flag_w;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_multi_core_ch #(
            .WIDTH       (WIDTH),
            .PRESC_WIDTH (PRESC_WIDTH)
        ) u_ch (
            .clk           (clk),
            .reset_n       (reset_n),
            .presc_init_i  (bus.prescaler_init),
            .limit_i       (bus.ch_limit[g]),
            .mode_i        (bus.ch_mode[g]),
            .start_i       (bus.start[g]),
            .stop_i        (bus.stop[g]),
            .event_clr_i   (bus.event_clr[g]),
            .timer_o       (timer_w[g]),
            .running_o     (running_w[g]),
            .event_pulse_o (pulse_w[g]),
            .event_o       (flag_w[g])
        );
    end

    assign bus.curr_timer  = timer_w;
    assign bus.running     = running_w;
    assign bus.event_pulse = pulse_w;
    assign bus.event_flag  = flag_w;
endmodule

// File: tb/tb_timer_multi_core.sv
// Directed bench for timer_multi_core (4 channels, 8-bit counters, 8-bit prescaler).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timer_multi_core;
    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int PW     = 8;

    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    timer_multi_core_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_WIDTH(PW)) bus ();

    timer_multi_core #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESC_WIDTH(PW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic edge_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        #3;
        n_assert++; if (bus.curr_timer !== '0) begin n_fail++; $display("FAIL reset_timer: got %h want 0", bus.curr_timer); end
        n_assert++; if (bus.running !== '0) begin n_fail++; $display("FAIL reset_running: got %b want 0", bus.running); end
        n_assert++; if (bus.event_pulse !== '0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", bus.event_pulse); end
        n_assert++; if (bus.event_flag !== '0) begin n_fail++; $display("FAIL reset_event: got %b want 0", bus.event_flag); end
        @(negedge clk); reset_n = 1'b1;
        edge_n(1);
    endtask

    task automatic test_reset_midcount;
        bus.prescaler_init = 8'd3; bus.ch_limit[0] = 8'd5; bus.ch_mode[0] = 2'd1;
        bus.start = 4'b0001; edge_n(1); bus.start = '0;
        edge_n(16);  // pulse after edge 15 sets event; timer now mid-count
        n_assert++; if (bus.event_flag[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_event: got %b want 1", bus.event_flag[0]); end
        #2 reset_n = 1'b0;
        #1;
        n_assert++; if (bus.curr_timer !== '0) begin n_fail++; $display("FAIL midrst_timer: got %h want 0", bus.curr_timer); end
        n_assert++; if (bus.running !== '0) begin n_fail++; $display("FAIL midrst_running: got %b want 0", bus.running); end
        n_assert++; if (bus.event_pulse !== '0) begin n_fail++; $display("FAIL midrst_pulse: got %b want 0", bus.event_pulse); end
        n_assert++; if (bus.event_flag !== '0) begin n_fail++; $display("FAIL midrst_event: got %b want 0", bus.event_flag); end
        @(negedge clk); reset_n = 1'b1;
        edge_n(5);
        n_assert++; if (bus.running[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_running: got %b want 0", bus.running[0]); end
        n_assert++; if (bus.curr_timer[0] !== 8'd0) begin n_fail++; $display("FAIL midrst_idle_timer: got %0d want 0", bus.curr_timer[0]); end
        bus.start = 4'b0001; edge_n(1); bus.start = '0;
        n_assert++; if (bus.running[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_restart_running: got %b want 1", bus.running[0]); end
        bus.stop = 4'b0001; edge_n(1); bus.stop = '0;
        n_assert++; if (bus.running[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_stop_latency: got %b want 0", bus.running[0]); end
    endtask

    task automatic test_oneshot;
        bus.prescaler_init = 8'd1; bus.ch_limit[0] = 8'd3; bus.ch_mode[0] = 2'd0;
        bus.start = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            edge_n(1); bus.start = '0;
            n_assert++; if (bus.running[0] !== 1'b1) begin n_fail++; $display("FAIL oneshot_running[%0d]: got %b want 1", k, bus.running[0]); end
            n_assert++; if (bus.curr_timer[0] !== 8'(k)) begin n_fail++; $display("FAIL oneshot_timer[%0d]: got %0d want %0d", k, bus.curr_timer[0], k); end
            n_assert++; if (bus.event_pulse[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_early_pulse[%0d]: got %b want 0", k, bus.event_pulse[0]); end
        end
        edge_n(1);
        n_assert++; if (bus.running[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_end_running: got %b want 0", bus.running[0]); end
        n_assert++; if (bus.event_pulse[0] !== 1'b1) begin n_fail++; $display("FAIL oneshot_pulse: got %b want 1", bus.event_pulse[0]); end
        n_assert++; if (bus.curr_timer[0] !== 8'd2) begin n_fail++; $display("FAIL oneshot_hold: got %0d want 2", bus.curr_timer[0]); end
        edge_n(3);
        n_assert++; if (bus.event_pulse[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_single_pulse: got %b want 0", bus.event_pulse[0]); end
        n_assert++; if (bus.event_flag[0] !== 1'b1) begin n_fail++; $display("FAIL oneshot_sticky: got %b want 1", bus.event_flag[0]); end
        n_assert++; if (bus.curr_timer[0] !== 8'd2) begin n_fail++; $display("FAIL oneshot_hold_late: got %0d want 2", bus.curr_timer[0]); end
        bus.event_clr = 4'b0001; edge_n(1); bus.event_clr = '0;
        n_assert++; if (bus.event_flag[0] !== 1'b0) begin n_fail++; $display("FAIL oneshot_clr: got %b want 0", bus.event_flag[0]); end
    endtask

    task automatic test_periodic;
        logic [7:0] exp_t;
        logic       exp_p;
        bus.prescaler_init = 8'd2; bus.ch_limit[1] = 8'd4; bus.ch_mode[1] = 2'd1;
        bus.start = 4'b0010;
        for (int c = 0; c <= 40; c++) begin
            edge_n(1); bus.start = '0;
            exp_t = 8'((c % 8) / 2);
            exp_p = (c > 0) && (c % 8 == 0);
            n_assert++; if (bus.curr_timer[1] !== exp_t) begin n_fail++; $display("FAIL periodic_timer c=%0d: got %0d want %0d", c, bus.curr_timer[1], exp_t); end
            n_assert++; if (bus.event_pulse[1] !== exp_p) begin n_fail++; $display("FAIL periodic_pulse c=%0d: got %b want %b", c, bus.event_pulse[1], exp_p); end
        end
        bus.stop = 4'b0010; bus.event_clr = 4'b0010; edge_n(1); bus.stop = '0; bus.event_clr = '0;
        n_assert++; if (bus.running[1] !== 1'b0) begin n_fail++; $display("FAIL periodic_stop: got %b want 0", bus.running[1]); end
    endtask

    task automatic test_freerun;
        logic [7:0] exp_t;
        logic       exp_p;
        bus.prescaler_init = 8'd1; bus.ch_limit[2] = 8'd5; bus.ch_mode[2] = 2'd2;
        bus.start = 4'b0100;
        for (int c = 0; c <= 512; c++) begin
            edge_n(1); bus.start = '0;
            if (c == 100) bus.ch_limit[2] = 8'd7;
            exp_t = 8'(c % 256);
            exp_p = (c > 0) && (c % 256 == 0);
            n_assert++; if (bus.curr_timer[2] !== exp_t) begin n_fail++; $display("FAIL free_timer c=%0d: got %0d want %0d", c, bus.curr_timer[2], exp_t); end
            n_assert++; if (bus.event_pulse[2] !== exp_p) begin n_fail++; $display("FAIL free_pulse c=%0d: got %b want %b", c, bus.event_pulse[2], exp_p); end
        end
        bus.stop = 4'b0100; bus.event_clr = 4'b0100; edge_n(1); bus.stop = '0; bus.event_clr = '0;
    endtask

    task automatic test_priority;
        int n;
        bus.prescaler_init = 8'd1; bus.ch_limit[0] = 8'd10; bus.ch_mode[0] = 2'd1;
        bus.start = 4'b0001; edge_n(1); bus.start = '0;
        edge_n(2);
        n_assert++; if (bus.curr_timer[0] !== 8'd2) begin n_fail++; $display("FAIL prio_pre_timer: got %0d want 2", bus.curr_timer[0]); end
        bus.start = 4'b0001; bus.stop = 4'b0001; edge_n(1); bus.start = '0; bus.stop = '0;
        n_assert++; if (bus.running[0] !== 1'b0) begin n_fail++; $display("FAIL prio_stopstart_running: got %b want 0", bus.running[0]); end
        edge_n(3);
        n_assert++; if (bus.curr_timer[0] !== 8'd2) begin n_fail++; $display("FAIL prio_stopstart_hold: got %0d want 2", bus.curr_timer[0]); end
        bus.start = 4'b0001; edge_n(1); bus.start = '0;
        edge_n(2);
        bus.start = 4'b0001; edge_n(1); bus.start = '0;
        n_assert++; if (bus.curr_timer[0] !== 8'd0) begin n_fail++; $display("FAIL prio_restart_timer: got %0d want 0", bus.curr_timer[0]); end
        n_assert++; if (bus.running[0] !== 1'b1) begin n_fail++; $display("FAIL prio_restart_running: got %b want 1", bus.running[0]); end
        edge_n(5);
        n_assert++; if (bus.curr_timer[0] !== 8'd5) begin n_fail++; $display("FAIL prio_after_restart: got %0d want 5", bus.curr_timer[0]); end
        // limit lowered below the count: must run through the 8-bit wrap first
        bus.ch_limit[0] = 8'd3;
        n = 0;
        while (bus.event_pulse[0] !== 1'b1 && n < 400) begin edge_n(1); n++; end
        n_assert++; if (n !== 254) begin n_fail++; $display("FAIL prio_lowered_limit_edges: got %0d want 254", n); end
        bus.event_clr = 4'b0001; edge_n(1); bus.event_clr = '0;
        n_assert++; if (bus.event_flag[0] !== 1'b0) begin n_fail++; $display("FAIL prio_clr: got %b want 0", bus.event_flag[0]); end
        edge_n(1);
        bus.event_clr = 4'b0001; edge_n(1); bus.event_clr = '0;
        n_assert++; if (bus.event_pulse[0] !== 1'b1) begin n_fail++; $display("FAIL prio_setclr_pulse: got %b want 1", bus.event_pulse[0]); end
        n_assert++; if (bus.event_flag[0] !== 1'b1) begin n_fail++; $display("FAIL prio_set_beats_clr: got %b want 1", bus.event_flag[0]); end
        bus.start = 4'b0001; edge_n(1); bus.start = '0;
        n_assert++; if (bus.event_flag[0] !== 1'b1) begin n_fail++; $display("FAIL prio_start_keeps_event: got %b want 1", bus.event_flag[0]); end
        bus.stop = 4'b0001; edge_n(1); bus.stop = '0;
        bus.event_clr = 4'b0001; edge_n(1); bus.event_clr = '0;
    endtask

    task automatic test_independence;
        int         lim [NUM_CH];
        logic [3:0] exp_p;
        lim = '{2, 3, 4, 5};
        bus.prescaler_init = 8'd2;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.ch_limit[i] = 8'(lim[i]);
            bus.ch_mode[i]  = 2'd1;
        end
        for (int c = 0; c <= 60; c++) begin
            bus.start = (c < NUM_CH) ? 4'(1 << c) : 4'b0000;
            edge_n(1);
            for (int i = 0; i < NUM_CH; i++)
                exp_p[i] = (c > i) && ((c - i) % (lim[i] * 2) == 0);
            n_assert++; if (bus.event_pulse !== exp_p) begin n_fail++; $display("FAIL indep_pulse c=%0d: got %b want %b", c, bus.event_pulse, exp_p); end
        end
        bus.start = '0;
        bus.stop = 4'hf; bus.event_clr = 4'hf; edge_n(1); bus.stop = '0; bus.event_clr = '0;
        n_assert++; if (bus.running !== 4'h0) begin n_fail++; $display("FAIL indep_stop_all: got %b want 0000", bus.running); end
    endtask

    task automatic test_zero_p_l;
        logic       exp_p;
        bus.prescaler_init = 8'd0; bus.ch_limit[3] = 8'd0; bus.ch_mode[3] = 2'd1;
        bus.start = 4'b1000;
        for (int c = 0; c <= 257; c++) begin
            edge_n(1); bus.start = '0;
            exp_p = (c == 256);
            n_assert++; if (bus.curr_timer[3] !== 8'(c % 256)) begin n_fail++; $display("FAIL zero_timer c=%0d: got %0d want %0d", c, bus.curr_timer[3], c % 256); end
            n_assert++; if (bus.event_pulse[3] !== exp_p) begin n_fail++; $display("FAIL zero_pulse c=%0d: got %b want %b", c, bus.event_pulse[3], exp_p); end
        end
        bus.stop = 4'b1000; edge_n(1); bus.stop = '0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.prescaler_init = '0;
        bus.ch_limit  = '0;
        bus.ch_mode   = '0;
        bus.start     = '0;
        bus.stop      = '0;
        bus.event_clr = '0;
        test_reset();
        test_reset_midcount();
        test_oneshot();
        test_periodic();
        test_freerun();
        test_priority();
        test_independence();
        test_zero_p_l();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
